// File: rtl/normalizer.sv
// Floating-point normalizer: turns an aligned two's-complement sum into sign/exponent/1.xxx mantissa.
// Optional round-to-nearest-even stage is compiled in with `define NORMALIZER_ROUND_EN.
module normalizer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [15:0] sum,
  input  logic [4:0] exp_max,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [4:0] out_exp,
  output logic [3:0] out_man,
  output logic       out_zero,
  output logic       out_ovf,
  output logic       out_unf
);

  // Handshake: a transfer happens on any rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither side buffers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
`ifdef NORMALIZER_ROUND_EN
    RND  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic              sign;
  logic [15:0]       mag;
  logic signed [6:0] exp;
  logic              norm_done;
  logic              load_res;

  logic [3:0]        man_r;
  logic signed [6:0] exp_r;
  logic              res_sign, res_zero, res_ovf, res_unf;
  logic [4:0]        res_exp;
  logic [3:0]        res_man;

  assign norm_done = (mag == 16'd0) || mag[15];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = NORM;
      NORM: begin
        if (norm_done) begin
`ifdef NORMALIZER_ROUND_EN
          state_next = RND;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef NORMALIZER_ROUND_EN
      RND:  state_next = DONE;
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
`ifdef NORMALIZER_ROUND_EN
    load_res  = (state == RND);
`else
    load_res  = (state == NORM) && norm_done;
`endif
  end

  // Result as it will appear at DONE entry: optional rounding, then exponent clamp.
  always_comb begin
    man_r = mag[15:12];
    exp_r = exp;
`ifdef NORMALIZER_ROUND_EN
    if (mag[11] && ((|mag[10:0]) || mag[12])) begin
      if (mag[15:12] == 4'hF) begin
        man_r = 4'b1000;
        exp_r = exp + 7'sd1;
      end else begin
        man_r = mag[15:12] + 4'd1;
      end
    end
`endif
    res_sign = sign;
    res_exp  = exp_r[4:0];
    res_man  = man_r;
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (mag == 16'd0) begin
      res_sign = 1'b0;
      res_exp  = 5'd0;
      res_man  = 4'd0;
      res_zero = 1'b1;
    end else if (exp_r > 7'sd15) begin
      res_exp  = 5'd15;
      res_man  = 4'b1111;
      res_ovf  = 1'b1;
    end else if (exp_r < -7'sd16) begin
      res_sign = 1'b0;
      res_exp  = 5'd0;
      res_man  = 4'd0;
      res_zero = 1'b1;
      res_unf  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign     <= 1'b0;
      mag      <= 16'd0;
      exp      <= 7'sd0;
      out_sign <= 1'b0;
      out_exp  <= 5'd0;
      out_man  <= 4'd0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sign <= sum[15];
        // Negating 0x8000 wraps back to 0x8000, which is the correct magnitude.
        mag  <= sum[15] ? (~sum + 16'd1) : sum;
        exp  <= {{2{exp_max[4]}}, exp_max} + 7'sd1;
      end else if (state == NORM && !norm_done) begin
        mag <= {mag[14:0], 1'b0};
        exp <= exp - 7'sd1;
      end
      if (load_res) begin
        out_sign <= res_sign;
        out_exp  <= res_exp;
        out_man  <= res_man;
        out_zero <= res_zero;
        out_ovf  <= res_ovf;
        out_unf  <= res_unf;
      end
    end
  end

endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1 bit: sum/exp_max valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept; transfer when in_valid & in_ready at an edge.
REQ-005 SHALL have port sum, input, 16 bits: two's-complement accumulated aligned sum; bit 14 weighs 2^exp_max.
REQ-006 SHALL have port exp_max, input, 5 bits: signed common exponent (-16..15).
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts; transfer when out_valid & out_ready at an edge.
REQ-009 SHALL have port out_sign, output, 1 bit: result sign.
REQ-010 SHALL have port out_exp, output, 5 bits: signed result exponent.
REQ-011 SHALL have port out_man, output, 4 bits: mantissa 1.xxx, bit 3 = explicit leading one.
REQ-012 SHALL have port out_zero, output, 1 bit: result is zero.
REQ-013 SHALL have port out_ovf, output, 1 bit: exponent saturated high.
REQ-014 SHALL have port out_unf, output, 1 bit: flushed to zero.

Function
REQ-015 SHALL implement FSM states IDLE, NORM, RND, DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE: on accept, SHALL capture sign = sum[15], mag = |sum| as 16-bit unsigned (0x8000 -> 0x8000), exp = exp_max + 1 in 7-bit signed, then go to NORM.
REQ-017 NORM: if mag == 0, SHALL set zero and leave; else if mag[15] == 0, SHALL shift mag left 1 and decrement exp, one bit per cycle; else leave.
REQ-018 Leaving NORM SHALL go to RND when ROUND_EN is defined, else to DONE.
REQ-019 Mantissa SHALL be mag[15:12]; guard = mag[11]; sticky = OR of mag[10:0].
REQ-020 Exponent clamp at DONE entry: exp > 15 -> out_exp = 15, out_man = 4'b1111, out_ovf = 1.
REQ-021 Exponent clamp at DONE entry: exp < -16 -> out_zero = 1, out_unf = 1, out_exp = 0, out_man = 0.
REQ-022 Zero result SHALL give out_exp = 0, out_man = 0, out_sign = 0.
REQ-023 Latency from accept edge to out_valid high SHALL be lz + 1 cycles, plus 1 with ROUND_EN, where lz = leading-zero count of mag (0 for zero input).
REQ-024 DONE SHALL hold out_valid and all result outputs stable until out_valid & out_ready, then go to IDLE.
REQ-025 in_valid while in_ready = 0 SHALL be ignored; no buffering.
REQ-026 In DONE, out_valid & out_ready SHALL transfer the result; the next input is not accepted before the following cycle.

Reset
REQ-027 rst SHALL force state IDLE, in_ready = 1, out_valid = 0, and all result outputs and internal registers to 0, in any state.
REQ-028 A reset during NORM, RND or DONE SHALL discard the operation; no out_valid pulse follows.

Configuration
REQ-029 Macro NORMALIZER_ROUND_EN SHALL select rounding behaviour.
REQ-030 With NORMALIZER_ROUND_EN defined, RND SHALL round to nearest even: increment mantissa if guard & (sticky | mag[12]); on carry-out, man = 4'b1000 and exp + 1, before clamping.
REQ-031 With NORMALIZER_ROUND_EN undefined, the mantissa SHALL be truncated and RND SHALL not exist.

Verification
REQ-032 Scenario: sum = 0x4000, exp_max = 3 -> sign 0, exp 3, man 1000, out_valid 2 cycles after accept (no round).
REQ-033 Scenario: sum = 0xF800, exp_max = 0 -> sign 1, exp -3, man 1000, out_valid 5 cycles after accept.
REQ-034 Scenario: sum = 0x0000 -> out_zero = 1, exp 0, man 0, out_valid 1 cycle after accept.
REQ-035 Scenario: sum = 0x7FFF, exp_max = 15 -> ROUND_EN: exp 15, man 1111, out_ovf = 1; no ROUND_EN: exp 15, man 1111, out_ovf = 0.
REQ-036 Scenario: sum = 0x0001, exp_max = -16 -> out_zero = 1, out_unf = 1.
REQ-037 Scenario: hold out_ready = 0 for 3 cycles in DONE with in_valid = 1 -> outputs stable, in_ready = 0, input not taken.
REQ-038 Scenario: rst asserted mid-NORM -> next cycle in_ready = 1, out_valid = 0, no result emitted.
